// File: rtl/kvs_lookup_responder_pkg.sv
// Shared op/result encodings and FSM states for the key-lookup responder.
package kvs_lookup_responder_pkg;

    localparam logic [3:0] OP_LOOKUP = 4'b0001;
    localparam logic [3:0] OP_INSERT = 4'b0010;
    localparam logic [3:0] OP_DELETE = 4'b0100;

    localparam logic [3:0] RES_NONE = 4'b0000;
    localparam logic [3:0] RES_HIT  = 4'b0001;
    localparam logic [3:0] RES_MISS = 4'b0010;
    localparam logic [3:0] RES_DONE = 4'b0100;
    localparam logic [3:0] RES_ERR  = 4'b1000;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/kvs_table_ram.sv
// Simple dual-port key table: one write port, one registered read port.
module kvs_table_ram #(
    parameter int W  = 97,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q;

    // Read returns the pre-write contents; the top forwards around it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kvs_lookup_responder.sv
// Key-lookup responder: init sweep FSM, 3-stage lookup pipeline,
// write-to-read forwarding and hit/miss statistics.
module kvs_lookup_responder
    import kvs_lookup_responder_pkg::*;
#(
    parameter int KEY_SIZE  = 96,
    parameter int IDX_BITS  = 10,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk156,
    input  logic                 eth_rst,
    input  logic [KEY_SIZE-1:0]  in_key,
    input  logic [3:0]           in_flag,
    input  logic                 in_valid,
    output logic                 out_valid,
    output logic [3:0]           out_flag,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    localparam int NCH  = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
    localparam int PADW = NCH * IDX_BITS;
    localparam int EW   = KEY_SIZE + 1;

    logic [0:0]           state_q;
    logic [IDX_BITS-1:0]  init_idx_q;

    logic                 s0_vld_q, s0_err_q;
    logic [3:0]           s0_op_q;
    logic [KEY_SIZE-1:0]  s0_key_q;
    logic [IDX_BITS-1:0]  s0_idx_q;

    logic                 s1_vld_q, s1_err_q;
    logic [3:0]           s1_op_q;
    logic [KEY_SIZE-1:0]  s1_key_q;
    logic [IDX_BITS-1:0]  s1_idx_q;

    logic                 fwd_vld_q, fwd_vld_d;
    logic [EW-1:0]        fwd_ent_q;

    logic                 out_valid_q;
    logic [3:0]           out_flag_q;
    logic [CNT_WIDTH-1:0] hit_q, miss_q;

    logic [PADW-1:0]      key_pad;
    logic [IDX_BITS-1:0]  hash_idx;
    logic [EW-1:0]        rd_ent, ent, wr_ent;
    logic                 ent_v, tag_eq, hit, wr_en;
    logic [3:0]           res;

    logic                 ram_we;
    logic [IDX_BITS-1:0]  ram_waddr;
    logic [EW-1:0]        ram_wdata;

    // XOR-fold of the key; the top chunk is zero-padded.
    always_comb begin
        key_pad  = PADW'(in_key);
        hash_idx = '0;
        for (int c = 0; c < NCH; c++) begin
            hash_idx = hash_idx ^ key_pad[c*IDX_BITS +: IDX_BITS];
        end
    end

    assign ent    = fwd_vld_q ? fwd_ent_q : rd_ent;
    assign ent_v  = ent[KEY_SIZE];
    assign tag_eq = (ent[KEY_SIZE-1:0] == s1_key_q);
    assign hit    = ent_v && tag_eq;

    always_comb begin
        wr_en  = 1'b0;
        wr_ent = ent;
        res    = RES_NONE;
        if (s1_err_q) begin
            res = RES_ERR;
        end else begin
            unique case (s1_op_q)
                OP_LOOKUP: res = hit ? RES_HIT : RES_MISS;
                OP_INSERT: begin
                    if (!ent_v || tag_eq) begin
                        wr_en  = s1_vld_q;
                        wr_ent = {1'b1, s1_key_q};
                        res    = RES_DONE;
                    end else begin
                        res = RES_ERR;
                    end
                end
                OP_DELETE: begin
                    if (hit) begin
                        wr_en  = s1_vld_q;
                        wr_ent = {1'b0, ent[KEY_SIZE-1:0]};
                        res    = RES_DONE;
                    end else begin
                        res = RES_MISS;
                    end
                end
                default: res = RES_NONE;
            endcase
        end
    end

    // A write landing on the index being read this cycle is forwarded.
    assign fwd_vld_d = wr_en && (s1_idx_q == s0_idx_q);

    always_comb begin
        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_idx_q;
            ram_wdata = '0;
        end else begin
            ram_we    = wr_en;
            ram_waddr = s1_idx_q;
            ram_wdata = wr_ent;
        end
    end

    kvs_table_ram #(
        .W  (EW),
        .AW (IDX_BITS)
    ) u_ram (
        .clk_i   (clk156),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (s0_idx_q),
        .rdata_o (rd_ent)
    );

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            s0_vld_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            fwd_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= RES_NONE;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            if (state_q == ST_INIT) begin
                init_idx_q <= init_idx_q + IDX_BITS'(1);
                if (&init_idx_q) begin
                    state_q <= ST_RUN;
                end
            end
            s0_vld_q    <= in_valid;
            s1_vld_q    <= s0_vld_q;
            fwd_vld_q   <= fwd_vld_d;
            out_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_flag_q <= res;
            end
            if (s1_vld_q && !s1_err_q && s1_op_q == OP_LOOKUP) begin
                if (hit) begin
                    hit_q <= hit_q + CNT_WIDTH'(1);
                end else begin
                    miss_q <= miss_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk156) begin
        s0_err_q  <= (state_q == ST_INIT);
        s0_op_q   <= in_flag;
        s0_key_q  <= in_key;
        s0_idx_q  <= hash_idx;
        s1_err_q  <= s0_err_q;
        s1_op_q   <= s0_op_q;
        s1_key_q  <= s0_key_q;
        s1_idx_q  <= s0_idx_q;
        fwd_ent_q <= wr_ent;
    end

    assign out_valid = out_valid_q;
    assign out_flag  = out_flag_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

endmodule
